uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 144 ++++++++++++++
 tb/tb_uart_rx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, per-bit cycle counter and a
// 3-sample mid-bit majority vote; each received byte is offered on valid/ready.
module uart_rx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int H = CLKS_PER_BIT / 2;
  localparam logic [7:0] CNT_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] CNT_S0   = 8'(H - 1);
  localparam logic [7:0] CNT_S1   = 8'(H);
  localparam logic [7:0] CNT_VOTE = 8'(H + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t     state;
  logic       rx_m;
  logic       rx_s;
  logic [7:0] cnt;
  logic [2:0] idx;
  logic       samp0;
  logic       samp1;
  logic [7:0] shreg;
  logic       done;
  logic       vote;

  // Third sample is rx_s itself, taken in the same cycle the vote is used.
  assign vote = (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      idx       <= 3'd0;
      samp0     <= 1'b1;
      samp1     <= 1'b1;
      shreg     <= 8'h00;
      done      <= 1'b0;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      done      <= 1'b0;
      frame_err <= 1'b0;

      if (state != IDLE && state != WAIT_HIGH) begin
        if (cnt == CNT_S0) samp0 <= rx_s;
        if (cnt == CNT_S1) samp1 <= rx_s;
      end

      case (state)
        IDLE: begin
          // The detection cycle is bit-cycle 0 of the start bit.
          if (!rx_s) begin
            state <= START;
            cnt   <= 8'd1;
          end
        end
        START: begin
          if (cnt == CNT_VOTE && vote) begin
            state <= IDLE;
            cnt   <= 8'd0;
          end else if (cnt == CNT_LAST) begin
            state <= DATA;
            cnt   <= 8'd0;
            idx   <= 3'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DATA: begin
          if (cnt == CNT_VOTE) shreg[idx] <= vote;
          if (cnt == CNT_LAST) begin
            cnt <= 8'd0;
            idx <= idx + 3'd1;
            if (idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        STOP: begin
          // Leave mid-stop-bit so a start edge right after one stop bit is caught.
          if (cnt == CNT_VOTE) begin
            cnt <= 8'd0;
            if (vote) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // valid/ready: a byte transfers on any cycle with valid && ready; data is
      // only reloaded when the slot is empty or being emptied in the same cycle.
      if (done) begin
        if (!valid || ready) begin
          data  <= shreg;
          valid <= 1'b1;
          if (valid) overrun <= 1'b0;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level expectation queue feeding a handshake model,
// per-cycle compare against the CLKS_PER_BIT=4 instance, plus directed checks.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;

  logic       rx16 = 1'b1;
  logic       ready16 = 1'b0;
  logic [7:0] data16;
  logic       valid16;
  logic       frame_err16;
  logic       overrun16;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  // Entry: {is_frame_err, edge number, byte}
  logic [31:0] exp_q[$];
  logic [7:0]  got_q[$];

  logic       m_valid = 1'b0;
  logic       m_ferr = 1'b0;
  logic       m_ovr = 1'b0;
  logic [7:0] m_data = 8'h00;

  int ferr_cnt = 0;
  int ferr16_cnt = 0;
  int valid_cyc = 0;
  int first_valid = -1;

  uart_rx #(.CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid),
    .ready(ready), .frame_err(frame_err), .overrun(overrun)
  );

  uart_rx #(.CLKS_PER_BIT(16)) dut16 (
    .clk(clk), .rst(rst), .rx(rx16), .data(data16), .valid(valid16),
    .ready(ready16), .frame_err(frame_err16), .overrun(overrun16)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- model ----------------
  // A frame whose line goes low right after edge F is decided at edge F+42
  // (2 sync + detect + 9 bits of 4 + vote offset 3) and presented at F+43.
  always @(posedge clk or posedge rst) begin : model
    int         n;
    logic       hit_b;
    logic       hit_f;
    logic [7:0] b;
    logic [31:0] e;
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= 8'h00;
      m_ovr   <= 1'b0;
      m_ferr  <= 1'b0;
      exp_q.delete();
    end else begin
      n     = cyc + 1;
      hit_b = 1'b0;
      hit_f = 1'b0;
      b     = 8'h00;
      while (exp_q.size() > 0 && int'(exp_q[0][30:8]) == n) begin
        e = exp_q.pop_front();
        if (e[31]) hit_f = 1'b1;
        else begin
          hit_b = 1'b1;
          b     = e[7:0];
        end
      end
      m_ferr <= hit_f;
      if (hit_b) begin
        if (!m_valid) begin
          m_valid <= 1'b1;
          m_data  <= b;
        end else if (ready) begin
          m_data <= b;
          m_ovr  <= 1'b0;
        end else begin
          m_ovr <= 1'b1;
        end
      end else if (m_valid && ready) begin
        m_valid <= 1'b0;
        m_ovr   <= 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("valid", {31'd0, valid}, {31'd0, m_valid});
    check("frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
    check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    if (m_valid) check("data", {24'd0, data}, {24'd0, m_data});
    if (valid) begin
      valid_cyc++;
      if (first_valid < 0) first_valid = cyc;
    end
    if (valid && ready) got_q.push_back(data);
    if (frame_err) ferr_cnt++;
    if (frame_err16) ferr16_cnt++;
  end

  // ---------------- drivers ----------------
  // Called at posedge+1; drives start, 8 data bits, low_stops zeros, nstop ones.
  task automatic send4(input logic [7:0] b, input int nstop, input int low_stops,
                       input int max_cyc, output int fall);
    logic [15:0] line;
    int nbits;
    line    = '1;
    line[0] = 1'b0;
    line[8:1] = b;
    for (int i = 0; i < low_stops; i++) line[9 + i] = 1'b0;
    nbits = 9 + low_stops + nstop;
    fall  = cyc;
    if (max_cyc >= nbits * 4) begin
      if (low_stops == 0) exp_q.push_back({1'b0, 23'(fall + 43), b});
      else exp_q.push_back({1'b1, 23'(fall + 42), 8'h00});
    end
    for (int j = 0; j < nbits * 4; j++) begin
      if (j >= max_cyc) break;
      rx = line[j / 4];
      tick(1);
    end
    rx = 1'b1;
  endtask

  // 16 clocks per bit; one of the three mid-bit samples (7,8,9) flipped per bit.
  task automatic send16(input logic [7:0] b);
    logic [15:0] line;
    int bi;
    int c;
    line    = '1;
    line[0] = 1'b0;
    line[8:1] = b;
    for (int j = 0; j < 12 * 16; j++) begin
      bi = j / 16;
      c  = j % 16;
      rx16 = line[bi] ^ (bi < 10 && c == 7 + (bi % 3));
      tick(1);
    end
    rx16 = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int f;
    int vc0;
    tick(3);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_data", {24'd0, data}, 32'h00);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_valid16", {31'd0, valid16}, 32'd0);
    rst = 1'b0;
    tick(5);

    // 0x6F, four stop bits, consumer always ready
    ready = 1'b1;
    send4(8'h6F, 4, 0, 1000, f);
    tick(5);
    check("t1_valid_cycles", valid_cyc, 1);
    check("t1_first_valid", first_valid, f + 43);
    check("t1_count", got_q.size(), 1);
    if (got_q.size() > 0) check("t1_byte", {24'd0, got_q.pop_front()}, 32'h6F);

    // one-clock low glitch on an idle line
    vc0 = valid_cyc;
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(20);
    check("t2_no_valid", valid_cyc, vc0);
    check("t2_no_ferr", ferr_cnt, 0);

    // 0xA5 with stop held low two bit times, then 0x3C
    send4(8'hA5, 4, 2, 1000, f);
    check("t3_ferr_pulses", ferr_cnt, 1);
    check("t3_a5_dropped", got_q.size(), 0);
    send4(8'h3C, 2, 0, 1000, f);
    tick(5);
    check("t3_count", got_q.size(), 1);
    if (got_q.size() > 0) check("t3_byte", {24'd0, got_q.pop_front()}, 32'h3C);
    check("t3_ferr_total", ferr_cnt, 1);

    // overrun: two back-to-back frames with ready low
    ready = 1'b0;
    send4(8'h11, 1, 0, 1000, f);
    send4(8'h22, 4, 0, 1000, f);
    tick(5);
    check("t4_valid", {31'd0, valid}, 32'd1);
    check("t4_data", {24'd0, data}, 32'h11);
    check("t4_overrun", {31'd0, overrun}, 32'd1);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    check("t4_valid_cleared", {31'd0, valid}, 32'd0);
    check("t4_overrun_cleared", {31'd0, overrun}, 32'd0);
    check("t4_count", got_q.size(), 1);
    if (got_q.size() > 0) check("t4_byte", {24'd0, got_q.pop_front()}, 32'h11);

    // reset in data bit 3 of 0x81 while a byte is pending
    send4(8'h55, 2, 0, 1000, f);
    tick(3);
    check("t5_pending", {24'd0, data}, 32'h55);
    send4(8'h81, 4, 0, 18, f);
    rst = 1'b1;
    #2;
    check("t5_rst_valid", {31'd0, valid}, 32'd0);
    check("t5_rst_data", {24'd0, data}, 32'h00);
    check("t5_rst_overrun", {31'd0, overrun}, 32'd0);
    check("t5_rst_frame_err", {31'd0, frame_err}, 32'd0);
    tick(2);
    rst = 1'b0;
    tick(4);
    send4(8'h42, 2, 0, 1000, f);
    tick(3);
    check("t5_valid", {31'd0, valid}, 32'd1);
    check("t5_data", {24'd0, data}, 32'h42);
    ready = 1'b1;
    tick(2);
    ready = 1'b0;
    check("t5_count", got_q.size(), 1);
    if (got_q.size() > 0) check("t5_byte", {24'd0, got_q.pop_front()}, 32'h42);

    // majority vote at 16 clocks per bit
    send16(8'h5A);
    tick(5);
    check("t6_valid16", {31'd0, valid16}, 32'd1);
    check("t6_data16", {24'd0, data16}, 32'h5A);
    check("t6_ferr16", ferr16_cnt, 0);
    check("t6_overrun16", {31'd0, overrun16}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
